// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch controller.
package stopwatch_pkg;

   // Controller states; encodings fixed so the state register is always 2 bits.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      HOLD  = 2'd3
   } sw_state_t;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_MAX        = 99;
   localparam int DEF_LAP_DEPTH  = 4;

   // Modulo increment: the value after max returns to zero.
   function automatic logic [31:0] wrap_inc(input logic [31:0] value, input logic [31:0] max);
      logic [31:0] result;
      if (value >= max) begin
         result = 32'd0;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_lap_fifo.sv
// Lap buffer: small FIFO with registered head/valid/level/overflow outputs,
// a sticky overflow flag and a flush that overrides any same-edge push or pop.
module lap_fifo
   import stopwatch_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LAP_DEPTH  = DEF_LAP_DEPTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [DATA_WIDTH-1:0]          push_data,
   input  logic                           flush,
   input  logic                           lap_ready,
   output logic [DATA_WIDTH-1:0]          lap_data,
   output logic                           lap_valid,
   output logic [$clog2(LAP_DEPTH+1)-1:0] lap_level,
   output logic                           lap_overflow
);

   localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int LVL_W = $clog2(LAP_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_r [LAP_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r, rd_next_s, wr_next_s;
   logic [LVL_W-1:0]      level_r, level_next_s;
   logic                  valid_r, valid_next_s;
   logic                  ovf_r, ovf_next_s;
   logic [DATA_WIDTH-1:0] head_r, head_next_s;
   logic                  pop_s, full_s, wr_en_s;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(LAP_DEPTH - 1)) begin
         r = {PTR_W{1'b0}};
      end else begin
         r = p + PTR_W'(1'b1);
      end
      return r;
   endfunction

   // Next pointers, occupancy, overflow and the head value seen after this edge.
   always_comb begin
      pop_s        = valid_r && lap_ready;
      full_s       = (level_r == LVL_W'(LAP_DEPTH));
      wr_en_s      = 1'b0;
      rd_next_s    = rd_ptr_r;
      wr_next_s    = wr_ptr_r;
      level_next_s = level_r;
      ovf_next_s   = ovf_r;
      head_next_s  = {DATA_WIDTH{1'b0}};
      if (flush) begin
         rd_next_s    = {PTR_W{1'b0}};
         wr_next_s    = {PTR_W{1'b0}};
         level_next_s = {LVL_W{1'b0}};
         ovf_next_s   = 1'b0;
      end else begin
         // A full buffer still takes a push if the head leaves on the same edge.
         wr_en_s = push && (!full_s || pop_s);
         if (push && full_s && !pop_s) begin
            ovf_next_s = 1'b1;
         end else begin
            ovf_next_s = ovf_r;
         end
         if (pop_s) begin
            rd_next_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_next_s = rd_ptr_r;
         end
         if (wr_en_s) begin
            wr_next_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_next_s = wr_ptr_r;
         end
         case ({wr_en_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1'b1);
            2'b01:   level_next_s = level_r - LVL_W'(1'b1);
            default: level_next_s = level_r;
         endcase
      end
      valid_next_s = (level_next_s != {LVL_W{1'b0}});
      // The new head is the slot being written when the buffer was empty
      // (or drained to exactly that slot), otherwise the stored entry.
      if (!valid_next_s) begin
         head_next_s = {DATA_WIDTH{1'b0}};
      end else if (wr_en_s && (rd_next_s == wr_ptr_r)) begin
         head_next_s = push_data;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
         head_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_ptr_r <= rd_next_s;
         wr_ptr_r <= wr_next_s;
         level_r  <= level_next_s;
         valid_r  <= valid_next_s;
         ovf_r    <= ovf_next_s;
         head_r   <= head_next_s;
      end
   end

   // Storage array; cleared on reset so no stale laps survive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAP_DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign lap_data     = head_r;
   assign lap_valid    = valid_r;
   assign lap_level    = level_r;
   assign lap_overflow = ovf_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, wrapping counter,
// freeze-on-lap display and a lap buffer for downstream consumption.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX        = DEF_MAX,
   parameter int LAP_DEPTH  = DEF_LAP_DEPTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           btn_ss,
   input  logic                           btn_lap,
   input  logic                           btn_clr,
   output logic [DATA_WIDTH-1:0]          count,
   output logic                           running,
   output logic                           frozen,
   output logic [DATA_WIDTH-1:0]          lap_data,
   output logic                           lap_valid,
   input  logic                           lap_ready,
   output logic [$clog2(LAP_DEPTH+1)-1:0] lap_level,
   output logic                           lap_overflow
);

   sw_state_t             state_r, state_next_s;
   logic [DATA_WIDTH-1:0] counter_r, counter_next_s;
   logic [DATA_WIDTH-1:0] hold_r, hold_next_s;
   logic [DATA_WIDTH-1:0] count_r, count_next_s;
   logic                  running_r, running_next_s;
   logic                  frozen_r, frozen_next_s;
   logic                  ss_s, lap_s, push_s, flush_s;

   // Next state, counter, hold register, lap push/flush and next outputs.
   always_comb begin
      // Priority: clear masks start/stop, start/stop masks lap.
      ss_s           = btn_ss && !btn_clr;
      lap_s          = btn_lap && !btn_clr && !btn_ss;
      state_next_s   = state_r;
      hold_next_s    = hold_r;
      counter_next_s = counter_r;
      push_s         = 1'b0;
      flush_s        = 1'b0;
      case (state_r)
         IDLE, PAUSE: begin
            if (btn_clr) begin
               state_next_s = IDLE;
               flush_s      = 1'b1;
            end else if (ss_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = state_r;
            end
         end
         RUN: begin
            if (btn_clr) begin
               state_next_s = RUN;
            end else if (ss_s) begin
               state_next_s = PAUSE;
            end else if (lap_s) begin
               state_next_s = HOLD;
               hold_next_s  = counter_r;
               push_s       = 1'b1;
            end else begin
               state_next_s = RUN;
            end
         end
         HOLD: begin
            if (btn_clr) begin
               state_next_s = HOLD;
            end else if (ss_s) begin
               state_next_s = PAUSE;
            end else if (lap_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase

      // The counter keeps ticking underneath a frozen display.
      if ((state_next_s == RUN) || (state_next_s == HOLD)) begin
         counter_next_s = DATA_WIDTH'(wrap_inc(32'(counter_r), 32'(MAX)));
      end else if (flush_s) begin
         counter_next_s = {DATA_WIDTH{1'b0}};
      end else begin
         counter_next_s = counter_r;
      end

      if (state_next_s == HOLD) begin
         count_next_s = hold_next_s;
      end else begin
         count_next_s = counter_next_s;
      end
      running_next_s = (state_next_s == RUN) || (state_next_s == HOLD);
      frozen_next_s  = (state_next_s == HOLD);
   end

   // State, counter, hold and registered display outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         counter_r <= {DATA_WIDTH{1'b0}};
         hold_r    <= {DATA_WIDTH{1'b0}};
         count_r   <= {DATA_WIDTH{1'b0}};
         running_r <= 1'b0;
         frozen_r  <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         counter_r <= counter_next_s;
         hold_r    <= hold_next_s;
         count_r   <= count_next_s;
         running_r <= running_next_s;
         frozen_r  <= frozen_next_s;
      end
   end

   assign count   = count_r;
   assign running = running_r;
   assign frozen  = frozen_r;

   lap_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .LAP_DEPTH  (LAP_DEPTH)
   ) u_lap_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push_s),
      .push_data    (counter_r),
      .flush        (flush_s),
      .lap_ready    (lap_ready),
      .lap_data     (lap_data),
      .lap_valid    (lap_valid),
      .lap_level    (lap_level),
      .lap_overflow (lap_overflow)
   );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_stopwatch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_ss, btn_lap, btn_clr, lap_ready;
   logic [15:0] count, lap_data;
   logic        running, frozen, lap_valid, lap_overflow;
   logic [2:0]  lap_level;

   localparam logic [6:0] MC = 7'h01, MR = 7'h02, MF = 7'h04, MV = 7'h08,
                          MD = 7'h10, ML = 7'h20, MO = 7'h40, MALL = 7'h7F;

   typedef struct {
      string       name;
      logic [6:0]  mask;
      logic [15:0] cnt;
      logic        run, frz, lv;
      logic [15:0] ld;
      logic [2:0]  lvl;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   n_total = 0;
   int   n_pass  = 0;
   logic bad;

   stopwatch_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .btn_ss       (btn_ss),
      .btn_lap      (btn_lap),
      .btn_clr      (btn_clr),
      .count        (count),
      .running      (running),
      .frozen       (frozen),
      .lap_data     (lap_data),
      .lap_valid    (lap_valid),
      .lap_ready    (lap_ready),
      .lap_level    (lap_level),
      .lap_overflow (lap_overflow)
   );

   always #5 clk = ~clk;

   // Monitor: compare the oldest expectation against the DUT at each falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         bad = 1'b0;
         if (cur.mask[0] && (count        !== cur.cnt)) bad = 1'b1;
         if (cur.mask[1] && (running      !== cur.run)) bad = 1'b1;
         if (cur.mask[2] && (frozen       !== cur.frz)) bad = 1'b1;
         if (cur.mask[3] && (lap_valid    !== cur.lv))  bad = 1'b1;
         if (cur.mask[4] && (lap_data     !== cur.ld))  bad = 1'b1;
         if (cur.mask[5] && (lap_level    !== cur.lvl)) bad = 1'b1;
         if (cur.mask[6] && (lap_overflow !== cur.ovf)) bad = 1'b1;
         n_total = n_total + 1;
         if (bad) begin
            $display("FAIL %s: got count=%0d run=%0b frz=%0b lv=%0b ld=%0d lvl=%0d ovf=%0b; want count=%0d run=%0b frz=%0b lv=%0b ld=%0d lvl=%0d ovf=%0b (mask %b)",
                     cur.name, count, running, frozen, lap_valid, lap_data, lap_level, lap_overflow,
                     cur.cnt, cur.run, cur.frz, cur.lv, cur.ld, cur.lvl, cur.ovf, cur.mask);
         end else begin
            n_pass = n_pass + 1;
         end
      end
   end

   task automatic exp_now(input string name, input logic [6:0] mask, input int cnt,
                          input logic run, input logic frz, input logic lv, input int ld,
                          input int lvl, input logic ovf);
      exp_t e;
      e.name = name; e.mask = mask; e.cnt = 16'(cnt); e.run = run; e.frz = frz;
      e.lv = lv; e.ld = 16'(ld); e.lvl = 3'(lvl); e.ovf = ovf;
      sb_q.push_back(e);
   endtask

   task automatic cyc(input logic ss, input logic lap, input logic clr);
      btn_ss = ss; btn_lap = lap; btn_clr = clr;
      @(posedge clk);
      #1;
      btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   // Starting from RUN at counter 1, take laps at 5, 10, 15, 20 with a release after each.
   task automatic fill4();
      for (int k = 0; k < 4; k++) begin
         run_n((k == 0) ? 4 : 3);
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0; lap_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_now("reset_state", MALL, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_n(2);
      exp_now("idle_after_reset", MALL, 0, 0, 0, 0, 0, 0, 0);

      // Run/pause.
      cyc(1'b1, 1'b0, 1'b0);
      run_n(8);
      cyc(1'b1, 1'b0, 1'b0);
      exp_now("run_pause", MC | MR | MF, 9, 0, 0, 0, 0, 0, 0);
      run_n(3);
      exp_now("pause_stable", MC | MR, 9, 0, 0, 0, 0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0);
      exp_now("resume", MC | MR, 10, 1, 0, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b1);
      exp_now("clr_in_run", MC | MR, 11, 1, 0, 0, 0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      exp_now("clr_ss_pause", MC | MR | MO, 0, 0, 0, 0, 0, 0, 0);

      // Wrap.
      cyc(1'b1, 1'b0, 1'b0);
      run_n(97);
      exp_now("wrap_98", MC, 98, 0, 0, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("wrap_99", MC, 99, 0, 0, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("wrap_0", MC, 0, 0, 0, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("wrap_1", MC, 1, 0, 0, 0, 0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);

      // Lap freeze and release.
      cyc(1'b1, 1'b0, 1'b0);
      run_n(24);
      cyc(1'b0, 1'b1, 1'b0);
      exp_now("lap_freeze", MALL, 25, 1, 1, 1, 25, 1, 0);
      run_n(3);
      exp_now("hold_const", MC | MF, 25, 0, 1, 0, 0, 0, 0);
      run_n(1);
      cyc(1'b0, 1'b1, 1'b0);
      exp_now("lap_release", MC | MR | MF | ML, 31, 1, 0, 0, 0, 1, 0);
      cyc(1'b1, 1'b1, 1'b0);
      exp_now("ss_lap_run", MC | MR | ML, 31, 0, 0, 0, 0, 1, 0);
      cyc(1'b0, 1'b1, 1'b0);
      exp_now("lap_in_pause", MC | MR | ML, 31, 0, 0, 0, 0, 1, 0);
      cyc(1'b0, 1'b0, 1'b1);
      exp_now("flush", MC | MV | MD | ML, 0, 0, 0, 0, 0, 0, 0);

      // Overflow with no consumer, then drain in order.
      cyc(1'b1, 1'b0, 1'b0);
      fill4();
      run_n(3);
      cyc(1'b0, 1'b1, 1'b0);
      exp_now("overflow", MALL, 25, 1, 1, 1, 5, 4, 1);
      lap_ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("drain_10", MV | MD | ML, 0, 0, 0, 1, 10, 3, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("drain_15", MV | MD | ML, 0, 0, 0, 1, 15, 2, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("drain_20", MV | MD | ML, 0, 0, 0, 1, 20, 1, 0);
      cyc(1'b0, 1'b0, 1'b0);
      lap_ready = 1'b0;
      exp_now("drained", MV | MD | ML | MO, 0, 0, 0, 0, 0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      exp_now("flush2", MC | ML | MO, 0, 0, 0, 0, 0, 0, 0);

      // Full buffer with push and pop on the same edge.
      cyc(1'b1, 1'b0, 1'b0);
      fill4();
      run_n(3);
      lap_ready = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      exp_now("push_pop_full", MALL, 25, 1, 1, 1, 10, 4, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("pp_drain_15", MV | MD | ML, 0, 0, 0, 1, 15, 3, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("pp_drain_20", MV | MD | ML, 0, 0, 0, 1, 20, 2, 0);
      cyc(1'b0, 1'b0, 1'b0);
      exp_now("pp_drain_25", MV | MD | ML, 0, 0, 0, 1, 25, 1, 0);
      cyc(1'b0, 1'b0, 1'b0);
      lap_ready = 1'b0;
      exp_now("pp_drained", MV | MD | ML | MO, 0, 0, 0, 0, 0, 0, 0);

      // Asynchronous reset while holding a lap.
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      exp_now("pre_reset", MF | MV | ML, 0, 0, 1, 1, 0, 1, 0);
      cyc(1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      exp_now("async_reset", MALL, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      exp_now("after_reset", MC | MR | MV | ML, 1, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
         n_total = n_total + 1;
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, count width; MAX, 99, terminal count before wrap; LAP_DEPTH, 4, lap buffer entries.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- btn_ss  in  1  start/stop pulse, one cycle.
- btn_lap  in  1  lap/release pulse, one cycle.
- btn_clr  in  1  clear pulse, one cycle.
- count  out  DATA_WIDTH  displayed time.
- running  out  1  high in RUN or HOLD.
- frozen  out  1  high in HOLD.
- lap_data  out  DATA_WIDTH  head of lap buffer.
- lap_valid  out  1  lap buffer non-empty.
- lap_ready  in  1  consumer accepts lap_data.
- lap_level  out  $clog2(LAP_DEPTH+1)  lap buffer occupancy.
- lap_overflow  out  1  sticky, lap dropped.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, HOLD.
REQ-004 The internal counter SHALL increment on every edge on which the next state is RUN or HOLD, wrap MAX->0, and hold otherwise.
REQ-005 Input priority per cycle SHALL be btn_clr > btn_ss > btn_lap; lower-priority pulses in the same cycle are discarded.
REQ-006 IDLE or PAUSE + btn_ss SHALL go to RUN and increment on that same edge.
REQ-007 RUN + btn_ss SHALL go to PAUSE with no increment on that edge.
REQ-008 RUN + btn_lap SHALL go to HOLD, load the hold register with the pre-edge counter value, push that value into the lap buffer, and increment the counter.
REQ-009 HOLD + btn_lap SHALL go to RUN without a push.
REQ-010 HOLD + btn_ss SHALL go to PAUSE.
REQ-011 btn_lap in IDLE or PAUSE SHALL be ignored.
REQ-012 btn_clr in IDLE or PAUSE SHALL go to IDLE, zero the counter, flush the lap buffer and clear lap_overflow. btn_clr in RUN or HOLD SHALL be ignored.
REQ-013 count SHALL equal the hold register in HOLD and the counter otherwise.
REQ-014 The lap buffer SHALL be FIFO-ordered. A push SHALL appear on lap_valid/lap_data on the next edge (1-cycle latency).
REQ-015 A pop SHALL occur on an edge where lap_valid && lap_ready.
REQ-016 Push when full with no same-edge pop SHALL drop the new value and set lap_overflow. Push and pop on the same edge when full SHALL accept both with no overflow.
REQ-017 A flush by btn_clr SHALL take precedence over a same-edge pop or push.
REQ-018 lap_data SHALL be 0 when lap_valid is low.

Reset
REQ-019 Asserting reset SHALL immediately force IDLE, counter 0, hold register 0, empty buffer, and every output 0, independent of clk.
REQ-020 Reset deassertion SHALL take effect from the first rising edge after release. A mid-run reset SHALL discard all laps.

Structure
REQ-021 Package stopwatch_pkg SHALL hold typedef sw_state_t (the four states) and the default parameter constants.
REQ-022 The lap buffer SHALL be the sub-module lap_fifo (parameters DATA_WIDTH and LAP_DEPTH, same clk/reset), instantiated once.

Verification (MAX=99, DATA_WIDTH=16, LAP_DEPTH=4)
REQ-023 Run/pause: reset, btn_ss, 10 edges with btn_ss on the 10th -> count=9 held, running=0. btn_ss again -> count=10 after that edge.
REQ-024 Wrap: from 0, run 100 increments -> count sequence ...98, 99, 0. Run one more -> count=1.
REQ-025 Lap: btn_lap when counter=25 -> frozen=1, count=25 constant, lap_valid=1 and lap_data=25 next edge. btn_lap when the internal counter=30 -> frozen=0, count=31 after that edge.
REQ-026 Overflow: lap_ready=0, laps at counts 5, 10, 15, 20 (release between each), then a fifth lap at 25 -> lap_level=4, lap_overflow=1, lap_data=5.
- Then lap_ready=1 for 4 edges -> data sequence 5, 10, 15, 20; lap_valid=0.
- Repeat the overflow case with push and pop on the same edge -> no overflow.
REQ-027 Simultaneous inputs:
- btn_ss+btn_lap in RUN -> PAUSE, lap_level unchanged.
- btn_clr+btn_ss in PAUSE -> IDLE, count=0, lap_overflow=0.
- btn_clr in RUN -> no change.
REQ-028 Async reset: assert reset mid-HOLD between edges -> count=0, lap_valid=0, running=0 before the next edge.
